muldiv_seq: RTL

//  Iterative RV32M multiply/divide sequencer in the EX stage of the 5-stage pipeline.

---
 rtl/muldiv_seq_pkg.sv | 60 ++++++
 rtl/muldiv_seq_md_core.sv | 91 +++++++++
 rtl/muldiv_seq.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
//   md_op_e    : funct3 encodings of the M-extension ops
//   md_state_e : sequencer FSM states
//   OPC_OP / F7_MULDIV : opcode/funct7 that identify an M-op upstream
//   helpers    : per-op operand signedness and result-negation rules
package muldiv_seq_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } md_state_e;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    function automatic logic is_m_op(input logic [6:0] opcode, input logic [6:0] funct7);
        return (opcode == OPC_OP) && (funct7 == F7_MULDIV);
    endfunction

    function automatic logic op_is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU) || (op == MD_REM) || (op == MD_REMU);
    endfunction

    // rs1 is treated as signed for every signed op including MULHSU
    function automatic logic op_a_signed(input md_op_e op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
               (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic op_b_signed(input md_op_e op);
        return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    // Whether the magnitude result must be negated, given the operand signs
    // (sign_a/sign_b already masked by the op's signedness).
    function automatic logic op_neg_res(input md_op_e op, input logic sign_a, input logic sign_b);
        logic neg;
        neg = 1'b0;
        case (op)
            MD_MUL, MD_MULH, MD_DIV: neg = sign_a ^ sign_b;
            MD_MULHSU, MD_REM:       neg = sign_a;
            default:                 neg = 1'b0;
        endcase
        return neg;
    endfunction

endpackage

// File: rtl/muldiv_seq_md_core.sv
// Shared 1-bit/cycle datapath for the multiply/divide sequencer.
// Multiply: shift-add, multiplier starts in the low half of acc and is
// consumed LSB first while the partial product grows into the high half.
// Divide: restoring shift/subtract; the quotient builds up in the low half of
// acc (dividend shifted out MSB first) and the remainder lives in rem.
// Ports:
//   clk, n_rst      clock / async active-low reset
//   load            capture magnitudes a_mag/b_mag, clear accumulators
//   step            perform one iteration for op
//   op              latched M-op (selects step kind and result field)
//   neg_res         negate the selected result (sign correction)
//   a_mag, b_mag    operand magnitudes (unsigned XLEN)
//   result          sign-corrected XLEN result, combinational from the regs
module md_core
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            load,
    input  logic            step,
    input  md_op_e          op,
    input  logic            neg_res,
    input  logic [XLEN-1:0] a_mag,
    input  logic [XLEN-1:0] b_mag,
    output logic [XLEN-1:0] result
);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   b_q,   b_d;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;

    always_comb begin
        acc_d = acc_q;
        rem_d = rem_q;
        b_d   = b_q;

        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? b_q : {XLEN{1'b0}})};
        div_shift = {rem_q, acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_q};

        if (load) begin
            acc_d = {{XLEN{1'b0}}, a_mag};
            rem_d = '0;
            b_d   = b_mag;
        end else if (step) begin
            if (op_is_div(op)) begin
                // Borrow out (div_diff[XLEN]) means the trial subtract failed: restore.
                acc_d[XLEN-1:0] = {acc_q[XLEN-2:0], ~div_diff[XLEN]};
                rem_d           = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
            end else begin
                acc_d = {mul_sum, acc_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            acc_q <= '0;
            rem_q <= '0;
            b_q   <= '0;
        end else begin
            acc_q <= acc_d;
            rem_q <= rem_d;
            b_q   <= b_d;
        end
    end

    always_comb begin
        prod_fix = neg_res ? -acc_q : acc_q;
        quo_fix  = neg_res ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = neg_res ? -rem_q : rem_q;
        result   = rem_fix;
        case (op)
            MD_MUL:                       result = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: result = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              result = quo_fix;
            default:                      result = rem_fix;
        endcase
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the EX stage.
// Accepts one M-op, stalls the front of the pipe while the shared datapath
// iterates one bit per cycle, then pulses MdDone with the registered result.
// Ports:
//   clk       clock, rising edge
//   n_rst     asynchronous reset, active low
//   MdStartE  M-op valid in EX
//   funct3E   M-op selector (MUL..REMU)
//   SrcAE     rs1 value, SrcBE rs2 value (sampled only on accept)
//   FlushE    EX flush; aborts any op in flight, wins over a same-cycle start
//   MdStall   freeze IF/ID/EX
//   MdDone    one-cycle pulse, MdResult valid
//   MdResult  registered result, held until the next completed op
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            MdStartE,
    input  logic [2:0]      funct3E,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic            FlushE,
    output logic            MdStall,
    output logic            MdDone,
    output logic [XLEN-1:0] MdResult
);

    localparam int CNT_W = $clog2(XLEN);

    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    md_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    md_op_e          op_q,    op_d;
    logic            neg_q,   neg_d;
    logic [XLEN-1:0] result_q, result_d;

    md_op_e          op_in;
    logic            sign_a_in;
    logic            sign_b_in;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            accept;
    logic            core_load;
    logic            core_step;
    logic [XLEN-1:0] core_result;

    // Operand preparation straight from the EX inputs; only used on accept.
    always_comb begin
        op_in     = md_op_e'(funct3E);
        sign_a_in = op_a_signed(op_in) & SrcAE[XLEN-1];
        sign_b_in = op_b_signed(op_in) & SrcBE[XLEN-1];
        // |INT_MIN| wraps back to INT_MIN, which is the right unsigned magnitude.
        a_mag     = sign_a_in ? -SrcAE : SrcAE;
        b_mag     = sign_b_in ? -SrcBE : SrcBE;
    end

    assign accept = (state_q == ST_IDLE) && MdStartE && !FlushE;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        neg_d     = neg_q;
        result_d  = result_q;
        core_load = 1'b0;
        core_step = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d      = op_in;
                    neg_d     = op_neg_res(op_in, sign_a_in, sign_b_in);
                    cnt_d     = CNT_W'(XLEN - 1);
                    core_load = 1'b1;
                    if (EARLY_OUT && op_is_div(op_in) && (SrcBE == '0)) begin
                        state_d  = ST_DONE;
                        result_d = ((op_in == MD_REM) || (op_in == MD_REMU)) ? SrcAE : ALL_ONES;
                    end else if (EARLY_OUT && ((op_in == MD_DIV) || (op_in == MD_REM)) &&
                                 (SrcAE == INT_MIN) && (SrcBE == ALL_ONES)) begin
                        state_d  = ST_DONE;
                        result_d = (op_in == MD_DIV) ? INT_MIN : '0;
                    end else begin
                        state_d = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                core_step = 1'b1;
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                result_d = core_result;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A flush abandons whatever is in flight and leaves the last result visible.
        if (FlushE) begin
            state_d   = ST_IDLE;
            result_d  = result_q;
            core_load = 1'b0;
            core_step = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= MD_MUL;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    md_core #(
        .XLEN (XLEN)
    ) u_md_core (
        .clk     (clk),
        .n_rst   (n_rst),
        .load    (core_load),
        .step    (core_step),
        .op      (op_q),
        .neg_res (neg_q),
        .a_mag   (a_mag),
        .b_mag   (b_mag),
        .result  (core_result)
    );

    assign MdStall  = accept || (state_q == ST_CALC) || (state_q == ST_FIX);
    assign MdDone   = (state_q == ST_DONE) && !FlushE;
    assign MdResult = result_q;

endmodule
